// File: rtl/bus_select_encoder_if.sv
// rtl/bus_select_encoder_if.sv - request/grant bundle between bus sources and the select encoder
//
// Signals:
//   req_in[15:0]     one request bit per bus source (bit i = source i)
//   ack              current bus transfer has been consumed
//   clear_err        synchronous clear of conflict_sticky
//   enc_out[3:0]     binary index of the granted source
//   grant_onehot     one-hot of the granted source
//   enc_valid        a grant is held
//   conflict         one-cycle pulse on a grant taken with two or more requests
//   conflict_sticky  latched conflict flag
//   timeout          one-cycle pulse on forced release
// Modports: master drives requests and observes grants; slave is the encoder.

interface bus_select_encoder_if;
    logic [15:0] req_in;
    logic        ack;
    logic        clear_err;
    logic [3:0]  enc_out;
    logic [15:0] grant_onehot;
    logic        enc_valid;
    logic        conflict;
    logic        conflict_sticky;
    logic        timeout;

    modport master (
        output req_in, ack, clear_err,
        input  enc_out, grant_onehot, enc_valid, conflict, conflict_sticky, timeout
    );

    modport slave (
        input  req_in, ack, clear_err,
        output enc_out, grant_onehot, enc_valid, conflict, conflict_sticky, timeout
    );
endinterface

// File: rtl/bus_select_encoder.sv
// rtl/bus_select_encoder.sv - round-robin 16-source bus select encoder with grant timeout
//
// Parameters:
//   TIMEOUT  grant cycles without ack before forced release (1..15)
// Ports:
//   clk      single clock, rising edge
//   clr      asynchronous active-low reset
//   bus      bus_select_encoder_if.slave (requests in, registered grant/status out)
// All outputs come straight from flops.

module bus_select_encoder #(
    parameter int TIMEOUT = 8
) (
    input  logic                    clk,
    input  logic                    clr,
    bus_select_encoder_if.slave     bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    state_t      state_q, state_next;
    logic [3:0]  ptr_q, ptr_next;
    logic [3:0]  cnt_q, cnt_next;
    logic [3:0]  enc_q, enc_next;
    logic [15:0] onehot_q, onehot_next;
    logic        valid_q, valid_next;
    logic        conflict_q, conflict_next;
    logic        sticky_q, sticky_next;
    logic        timeout_q, timeout_next;

    logic [3:0]  pick;
    logic [3:0]  idx;
    logic        found;
    logic        any_req;
    logic        multi_req;
    logic        expire;

    assign any_req   = |bus.req_in;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_req = |(bus.req_in & (bus.req_in - 16'd1));
    assign expire    = (cnt_q == CNT_LAST);

    // Round-robin search: first set bit starting just above the last granted index.
    // The 4-bit sum wraps 15 -> 0 by itself; offset 16 revisits ptr_q last.
    always_comb begin
        pick  = 4'd0;
        idx   = 4'd0;
        found = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            idx = ptr_q + 4'(i);
            if (!found && bus.req_in[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // State register plus the registered outputs and datapath.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= IDLE;
            ptr_q      <= 4'd15;
            cnt_q      <= 4'd0;
            enc_q      <= 4'd0;
            onehot_q   <= 16'd0;
            valid_q    <= 1'b0;
            conflict_q <= 1'b0;
            sticky_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_next;
            ptr_q      <= ptr_next;
            cnt_q      <= cnt_next;
            enc_q      <= enc_next;
            onehot_q   <= onehot_next;
            valid_q    <= valid_next;
            conflict_q <= conflict_next;
            sticky_q   <= sticky_next;
            timeout_q  <= timeout_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:    if (any_req)          state_next = GRANT;
            GRANT:   if (bus.ack || expire) state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    // Next values for the registered outputs.
    always_comb begin
        ptr_next      = ptr_q;
        cnt_next      = cnt_q;
        enc_next      = enc_q;
        onehot_next   = onehot_q;
        valid_next    = valid_q;
        conflict_next = 1'b0;
        timeout_next  = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    enc_next      = pick;
                    onehot_next   = 16'd1 << pick;
                    valid_next    = 1'b1;
                    conflict_next = multi_req;
                    cnt_next      = 4'd0;
                end else begin
                    enc_next    = 4'd0;
                    onehot_next = 16'd0;
                    valid_next  = 1'b0;
                end
            end
            GRANT: begin
                // ack takes priority so a same-cycle expiry is a normal release.
                if (bus.ack || expire) begin
                    ptr_next     = enc_q;
                    enc_next     = 4'd0;
                    onehot_next  = 16'd0;
                    valid_next   = 1'b0;
                    timeout_next = !bus.ack;
                end else begin
                    cnt_next = cnt_q + 4'd1;
                end
            end
            default: begin
                enc_next    = 4'd0;
                onehot_next = 16'd0;
                valid_next  = 1'b0;
            end
        endcase

        // Set beats clear when both happen together.
        sticky_next = conflict_next | (sticky_q & ~bus.clear_err);
    end

    assign bus.enc_out         = enc_q;
    assign bus.grant_onehot    = onehot_q;
    assign bus.enc_valid       = valid_q;
    assign bus.conflict        = conflict_q;
    assign bus.conflict_sticky = sticky_q;
    assign bus.timeout         = timeout_q;

endmodule

// File: doc/bus_select_encoder.md
BUS_SELECT_ENCODER -- requirements
Module: bus_select_encoder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8, meaning the number of GRANT cycles without ack before forced release; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port clr, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port req_in, input, 16, one request bit per bus source (bit i = source i).
REQ-005 SHALL have port ack, input, 1, meaning the current bus transfer has been consumed.
REQ-006 SHALL have port clear_err, input, 1, a synchronous clear of conflict_sticky.
REQ-007 SHALL have port enc_out, output, 4, the registered binary index of the granted source.
REQ-008 SHALL have port grant_onehot, output, 16, the registered one-hot of the granted source; it SHALL always equal the 4-to-16 decode of enc_out while enc_valid=1.
REQ-009 SHALL have port enc_valid, output, 1, asserted while a grant is held.
REQ-010 SHALL have port conflict, output, 1, a one-cycle pulse accompanying a grant taken while two or more requests were present.
REQ-011 SHALL have port conflict_sticky, output, 1, the latched conflict flag.
REQ-012 SHALL have port timeout, output, 1, a one-cycle pulse on forced release.

Function
REQ-013 SHALL implement two states, IDLE and GRANT, plus a 4-bit round-robin pointer ptr holding the last granted index.
REQ-014 IDLE with req_in=0: SHALL stay in IDLE with enc_valid=0, enc_out=0 and grant_onehot=0.
REQ-015 IDLE with req_in!=0: SHALL pick the first set bit searching upward from ptr+1 mod 16, wrapping 15->0.
REQ-016 On that pick, the next edge SHALL register enc_out, grant_onehot and enc_valid=1 and enter GRANT; request-to-valid latency is exactly 1 cycle.
REQ-017 In GRANT, enc_out and grant_onehot SHALL stay stable regardless of req_in changes, including deassertion of the granted bit.
REQ-018 In GRANT with ack=1: the next edge SHALL set ptr to the granted index, clear enc_valid, enc_out and grant_onehot, and return to IDLE; this gives a minimum of one enc_valid-low cycle between grants.
REQ-019 A cycle counter SHALL clear on GRANT entry and increment each GRANT cycle without ack.
REQ-020 When the counter reaches TIMEOUT-1 and ack=0, the next edge SHALL release exactly as in REQ-018 and pulse timeout for one cycle.
REQ-021 ack and the timeout condition in the same cycle: ack SHALL win and timeout SHALL not pulse.
REQ-022 ack while in IDLE SHALL be ignored.
REQ-023 conflict SHALL pulse on the same edge enc_valid rises when popcount(req_in) was at least 2 at the arbitration cycle; it SHALL otherwise be 0.
REQ-024 conflict_sticky SHALL set with any conflict pulse and clear on clear_err=1.
REQ-025 A simultaneous set and clear of conflict_sticky SHALL leave it set.
REQ-026 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-027 While clr=0: enc_out=0, grant_onehot=0, enc_valid=0, conflict=0, conflict_sticky=0, timeout=0, state=IDLE, counter=0 and ptr=15, so source 0 has first priority.
REQ-028 Reset asserted mid-GRANT SHALL drop the grant immediately (asynchronously) with no timeout pulse.
REQ-029 After clr rises, the first arbitration SHALL occur on the first edge that sees req_in!=0.

Verification
REQ-030 Bench SHALL cover: after reset, req_in=16'h0001 -> one cycle later enc_out=0, grant_onehot=16'h0001, enc_valid=1, conflict=0.
REQ-031 Bench SHALL cover: req_in=16'h8009 held with ack pulsed each grant -> grants in order 0, 3, 15, 0, each followed by one invalid cycle; conflict pulses on every grant; conflict_sticky=1.
REQ-032 Bench SHALL cover: a grant of source 5 with no ack and TIMEOUT=8 -> enc_valid high for 8 cycles, then timeout=1 for one cycle with enc_valid=0, and the next grant searches from index 6.
REQ-033 Bench SHALL cover: ack on the same cycle the counter reaches TIMEOUT-1 -> normal release, timeout stays 0.
REQ-034 Bench SHALL cover: clear_err=1 in the same cycle a conflict grant occurs -> conflict_sticky=1; clear_err=1 alone next cycle -> conflict_sticky=0.
REQ-035 Bench SHALL cover: clr=0 while granting source 9 -> enc_out=0, grant_onehot=0, enc_valid=0 without waiting for a clock edge; after release, req_in=16'hFFFF -> source 0 granted first.
